// File: rtl/time_set_ctrl.sv
// Button-driven time entry: debounced mode/up/down buttons walk an hours->minutes->seconds
// edit of a packed BCD time word, committed to the display bus with a one-cycle valid pulse.

module time_set_debounce #(
    parameter int unsigned CYCLES = 100000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic press_o
);
    localparam int CW = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic          syncMeta_q;
    logic          syncLevel_q;
    logic          level_q;
    logic          level_d;
    logic          levelDly_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The level is only accepted after CYCLES consecutive cycles of disagreement.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (syncLevel_q != level_q) begin
            if (cnt_q == LAST) begin
                level_d = syncLevel_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            syncMeta_q  <= 1'b0;
            syncLevel_q <= 1'b0;
            level_q     <= 1'b0;
            levelDly_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            syncMeta_q  <= btn_i;
            syncLevel_q <= syncMeta_q;
            level_q     <= level_d;
            levelDly_q  <= level_q;
            cnt_q       <= cnt_d;
        end
    end

    assign press_o = level_q & ~levelDly_q;
endmodule

module time_set_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 100000,
    parameter int unsigned TIMEOUT_CYCLES  = 1000000000,
    parameter int unsigned BLINK_CYCLES    = 50000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_mode,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic [19:0] cur_time,
    output logic [19:0] set_time,
    output logic        set_valid,
    output logic        editing,
    output logic [5:0]  blank_mask
);
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_EDIT_HR  = 3'd1;
    localparam logic [2:0] ST_EDIT_MIN = 3'd2;
    localparam logic [2:0] ST_EDIT_SEC = 3'd3;
    localparam logic [2:0] ST_COMMIT   = 3'd4;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BW = $clog2(BLINK_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_CYCLES - 1);

    logic          modePress;
    logic          upPress;
    logic          downPress;
    logic [2:0]    state_q;
    logic [2:0]    state_d;
    logic [19:0]   shadow_q;
    logic [19:0]   shadow_d;
    logic [19:0]   committed_q;
    logic [19:0]   committed_d;
    logic [TW-1:0] timeout_q;
    logic [TW-1:0] timeout_d;
    logic [BW-1:0] blinkCnt_q;
    logic [BW-1:0] blinkCnt_d;
    logic          blink_q;
    logic          blink_d;
    logic          inEdit;
    logic          stepReq;
    logic          timeoutHit;
    logic [2:0]    selTens;
    logic [3:0]    selUnits;
    logic [2:0]    maxTens;
    logic [3:0]    maxUnits;
    logic [6:0]    fieldNext;

    time_set_debounce #(.CYCLES(DEBOUNCE_CYCLES)) uDebMode (
        .clk_i(clk), .rst_ni(reset), .btn_i(btn_mode), .press_o(modePress)
    );
    time_set_debounce #(.CYCLES(DEBOUNCE_CYCLES)) uDebUp (
        .clk_i(clk), .rst_ni(reset), .btn_i(btn_up), .press_o(upPress)
    );
    time_set_debounce #(.CYCLES(DEBOUNCE_CYCLES)) uDebDown (
        .clk_i(clk), .rst_ni(reset), .btn_i(btn_down), .press_o(downPress)
    );

    // Out-of-range fields are treated as sitting at their maximum value.
    function automatic logic [6:0] stepField(
        input logic [2:0] tens,
        input logic [3:0] units,
        input logic [2:0] limTens,
        input logic [3:0] limUnits,
        input logic       up
    );
        logic       outOfRange;
        logic       atMax;
        logic       atZero;
        logic [6:0] result;
        outOfRange = (units > 4'd9) || (tens > limTens) ||
                     ((tens == limTens) && (units > limUnits));
        atMax      = outOfRange || ((tens == limTens) && (units == limUnits));
        atZero     = (tens == 3'd0) && (units == 4'd0);
        if (up) begin
            if (atMax) begin
                result = 7'd0;
            end else if (units == 4'd9) begin
                result = {tens + 3'd1, 4'd0};
            end else begin
                result = {tens, units + 4'd1};
            end
        end else begin
            if (outOfRange || atZero) begin
                result = {limTens, limUnits};
            end else if (units == 4'd0) begin
                result = {tens - 3'd1, 4'd9};
            end else begin
                result = {tens, units - 4'd1};
            end
        end
        return result;
    endfunction

    assign inEdit     = (state_q == ST_EDIT_HR) || (state_q == ST_EDIT_MIN) ||
                        (state_q == ST_EDIT_SEC);
    assign stepReq    = inEdit && !modePress && (upPress ^ downPress);
    assign timeoutHit = (timeout_q == TIMEOUT_LAST);

    always_comb begin
        selTens  = shadow_q[6:4];
        selUnits = shadow_q[3:0];
        maxTens  = 3'd5;
        maxUnits = 4'd9;
        case (state_q)
            ST_EDIT_HR: begin
                selTens  = {1'b0, shadow_q[19:18]};
                selUnits = shadow_q[17:14];
                maxTens  = 3'd2;
                maxUnits = 4'd3;
            end
            ST_EDIT_MIN: begin
                selTens  = shadow_q[13:11];
                selUnits = shadow_q[10:7];
            end
            default: ;
        endcase
        fieldNext = stepField(selTens, selUnits, maxTens, maxUnits, upPress);
    end

    // Mode presses take priority over a timeout landing in the same cycle.
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        committed_d = committed_q;
        case (state_q)
            ST_IDLE: begin
                if (modePress) begin
                    state_d  = ST_EDIT_HR;
                    shadow_d = cur_time;
                end
            end
            ST_EDIT_HR: begin
                if (modePress) begin
                    state_d = ST_EDIT_MIN;
                end else if (timeoutHit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_EDIT_MIN: begin
                if (modePress) begin
                    state_d = ST_EDIT_SEC;
                end else if (timeoutHit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_EDIT_SEC: begin
                if (modePress) begin
                    state_d     = ST_COMMIT;
                    committed_d = shadow_q;
                end else if (timeoutHit) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (stepReq) begin
            case (state_q)
                ST_EDIT_HR:  shadow_d[19:14] = {fieldNext[5:4], fieldNext[3:0]};
                ST_EDIT_MIN: shadow_d[13:7]  = fieldNext;
                default:     shadow_d[6:0]   = fieldNext;
            endcase
        end
    end

    always_comb begin
        if (!inEdit || modePress || stepReq) begin
            timeout_d = '0;
        end else begin
            timeout_d = timeout_q + 1'b1;
        end
    end

    // The blink phase restarts so a freshly changed field is visible immediately.
    always_comb begin
        blinkCnt_d = blinkCnt_q + 1'b1;
        blink_d    = blink_q;
        if ((state_d != state_q) || stepReq) begin
            blinkCnt_d = '0;
            blink_d    = 1'b0;
        end else if (blinkCnt_q == BLINK_LAST) begin
            blinkCnt_d = '0;
            blink_d    = ~blink_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            shadow_q    <= '0;
            committed_q <= '0;
            timeout_q   <= '0;
            blinkCnt_q  <= '0;
            blink_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            committed_q <= committed_d;
            timeout_q   <= timeout_d;
            blinkCnt_q  <= blinkCnt_d;
            blink_q     <= blink_d;
        end
    end

    always_comb begin
        case (state_q)
            ST_EDIT_HR:  blank_mask = {blink_q, blink_q, 4'b0000};
            ST_EDIT_MIN: blank_mask = {2'b00, blink_q, blink_q, 2'b00};
            ST_EDIT_SEC: blank_mask = {4'b0000, blink_q, blink_q};
            default:     blank_mask = 6'b000000;
        endcase
    end

    assign editing   = inEdit;
    assign set_valid = (state_q == ST_COMMIT);
    assign set_time  = inEdit ? shadow_q : committed_q;
endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: field-arithmetic vector table, hand-written
// corner sequences, and a randomized run against an integer hours/minutes/seconds model.

module tb_time_set_ctrl;
    localparam int DEB = 4;
    localparam int TO  = 50;
    localparam int BL  = 10;
    localparam logic [2:0] B_MODE = 3'b100;
    localparam logic [2:0] B_UP   = 3'b010;
    localparam logic [2:0] B_DOWN = 3'b001;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn_mode;
    logic        btn_up;
    logic        btn_down;
    logic [19:0] cur_time;
    logic [19:0] set_time;
    logic        set_valid;
    logic        editing;
    logic [5:0]  blank_mask;

    int          compared   = 0;
    int          mismatched = 0;
    int          validCount = 0;
    logic [19:0] validTime  = '0;

    typedef struct {
        logic [19:0] load;
        int          field;
        logic        up;
        logic [19:0] expv;
    } vec_t;

    vec_t vecs[14];

    always #5 clk = ~clk;

    time_set_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TO),
        .BLINK_CYCLES   (BL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_mode  (btn_mode),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .cur_time  (cur_time),
        .set_time  (set_time),
        .set_valid (set_valid),
        .editing   (editing),
        .blank_mask(blank_mask)
    );

    // Every commit pulse is counted and the time it carried is remembered.
    always @(negedge clk) begin
        if (set_valid) begin
            validCount = validCount + 1;
            validTime  = set_time;
        end
    end

    function automatic logic [19:0] pk(input int ht, input int hu, input int mt,
                                       input int mu, input int st, input int su);
        return {ht[1:0], hu[3:0], mt[2:0], mu[3:0], st[2:0], su[3:0]};
    endfunction

    function automatic logic [19:0] packTime(input int h, input int m, input int s);
        return pk(h / 10, h % 10, m / 10, m % 10, s / 10, s % 10);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared = compared + 1;
        if (act !== exp) begin
            mismatched = mismatched + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] btns, input int hold, input int rel);
        @(posedge clk);
        #1;
        {btn_mode, btn_up, btn_down} = btns;
        repeat (hold) @(posedge clk);
        #1;
        {btn_mode, btn_up, btn_down} = 3'b000;
        repeat (rel) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic press(input logic [2:0] btns);
        applyStimulus(btns, 10, 10);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b0;
        {btn_mode, btn_up, btn_down} = 3'b000;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic waitMask(input int bound, output logic [5:0] seen);
        seen = blank_mask;
        for (int i = 0; i < bound && seen == 6'b0; i++) begin
            @(negedge clk);
            seen = blank_mask;
        end
    endtask

    initial begin
        logic [5:0] mask;
        int         base;
        int         waited;
        int         expValid;
        int         mState;
        int         sh0, sh1, sh2, cm0, cm1, cm2, c0, c1, c2;
        int         op;

        reset    = 1'b0;
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        cur_time = '0;

        vecs[0]  = '{pk(2,3,1,5,4,2), 0, 1'b1, pk(0,0,1,5,4,2)};
        vecs[1]  = '{pk(0,0,1,5,4,2), 0, 1'b0, pk(2,3,1,5,4,2)};
        vecs[2]  = '{pk(0,9,1,5,4,2), 0, 1'b1, pk(1,0,1,5,4,2)};
        vecs[3]  = '{pk(1,9,1,5,4,2), 0, 1'b1, pk(2,0,1,5,4,2)};
        vecs[4]  = '{pk(1,2,5,9,0,7), 1, 1'b1, pk(1,2,0,0,0,7)};
        vecs[5]  = '{pk(1,2,0,9,0,7), 1, 1'b1, pk(1,2,1,0,0,7)};
        vecs[6]  = '{pk(1,2,0,0,0,7), 1, 1'b0, pk(1,2,5,9,0,7)};
        vecs[7]  = '{pk(1,2,3,4,1,0), 2, 1'b0, pk(1,2,3,4,0,9)};
        vecs[8]  = '{pk(1,2,3,4,5,9), 2, 1'b1, pk(1,2,3,4,0,0)};
        vecs[9]  = '{pk(2,7,3,4,5,6), 0, 1'b1, pk(0,0,3,4,5,6)};
        vecs[10] = '{pk(2,7,3,4,5,6), 0, 1'b0, pk(2,3,3,4,5,6)};
        vecs[11] = '{pk(1,2,4,12,5,6), 1, 1'b1, pk(1,2,0,0,5,6)};
        vecs[12] = '{pk(1,2,3,4,7,1), 2, 1'b0, pk(1,2,3,4,5,9)};
        vecs[13] = '{pk(3,0,3,4,5,6), 0, 1'b1, pk(0,0,3,4,5,6)};

        repeat (2) @(negedge clk);
        checkOutput("resetSetTime", 32'(set_time), 32'h0);
        checkOutput("resetValid", 32'(set_valid), 32'h0);
        checkOutput("resetEditing", 32'(editing), 32'h0);
        checkOutput("resetMask", 32'(blank_mask), 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // Entry, debounce rejection of short glitches, single press for a long hold.
        cur_time = pk(1,2,3,4,5,6);
        repeat (5) applyStimulus(B_MODE, 3, 3);
        checkOutput("glitchModeIdle", 32'(editing), 32'h0);
        press(B_MODE);
        checkOutput("enterEditing", 32'(editing), 32'h1);
        checkOutput("enterShadow", 32'(set_time), 32'(pk(1,2,3,4,5,6)));
        repeat (2) applyStimulus(B_UP, 3, 3);
        checkOutput("glitchUpEdit", 32'(set_time), 32'(pk(1,2,3,4,5,6)));
        applyStimulus(B_UP, 20, 10);
        checkOutput("holdUpOnce", 32'(set_time), 32'(pk(1,3,3,4,5,6)));

        for (int i = 0; i < 14; i++) begin
            doReset();
            cur_time = vecs[i].load;
            press(B_MODE);
            repeat (vecs[i].field) press(B_MODE);
            press(vecs[i].up ? B_UP : B_DOWN);
            checkOutput($sformatf("vec%0d", i), 32'(set_time), 32'(vecs[i].expv));
        end

        // Full edit-and-commit of 07:34:56.
        doReset();
        cur_time = pk(1,2,3,4,5,6);
        press(B_MODE);
        waitMask(12, mask);
        checkOutput("blinkHours", 32'(mask), 32'h30);
        repeat (5) press(B_DOWN);
        checkOutput("hoursDown5", 32'(set_time), 32'(pk(0,7,3,4,5,6)));
        base = validCount;
        repeat (3) press(B_MODE);
        checkOutput("commitPulses", 32'(validCount - base), 32'h1);
        checkOutput("commitTime", 32'(validTime), 32'(pk(0,7,3,4,5,6)));
        checkOutput("commitIdle", 32'(editing), 32'h0);
        repeat (10) @(negedge clk);
        checkOutput("commitHold", 32'(set_time), 32'(pk(0,7,3,4,5,6)));
        checkOutput("idleMask", 32'(blank_mask), 32'h0);

        // Edit abandoned by timeout falls back to the committed time.
        cur_time = pk(1,1,1,1,1,1);
        press(B_MODE);
        checkOutput("toEnter", 32'(set_time), 32'(pk(1,1,1,1,1,1)));
        press(B_MODE);
        press(B_UP);
        checkOutput("toMinUp", 32'(set_time), 32'(pk(1,1,1,2,1,1)));
        repeat (25) @(negedge clk);
        checkOutput("toNotEarly", 32'(editing), 32'h1);
        waited = 0;
        while (editing && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("toAbort", 32'(editing), 32'h0);
        checkOutput("toRevert", 32'(set_time), 32'(pk(0,7,3,4,5,6)));
        checkOutput("toNoValid", 32'(validCount - base), 32'h1);

        // Simultaneous presses, then reset in the middle of a minutes edit.
        doReset();
        cur_time = pk(1,2,3,4,5,6);
        press(B_MODE);
        press(B_MODE | B_UP);
        checkOutput("modeUpEditing", 32'(editing), 32'h1);
        checkOutput("modeUpNoChange", 32'(set_time), 32'(pk(1,2,3,4,5,6)));
        press(B_UP);
        checkOutput("minutesSelected", 32'(set_time), 32'(pk(1,2,3,5,5,6)));
        press(B_UP | B_DOWN);
        checkOutput("upDownIgnored", 32'(set_time), 32'(pk(1,2,3,5,5,6)));
        waitMask(12, mask);
        checkOutput("blinkMinutes", 32'(mask), 32'h0C);
        reset = 1'b0;
        #1;
        checkOutput("midResetTime", 32'(set_time), 32'h0);
        checkOutput("midResetEditing", 32'(editing), 32'h0);
        checkOutput("midResetMask", 32'(blank_mask), 32'h0);
        checkOutput("midResetValid", 32'(set_valid), 32'h0);
        reset = 1'b1;

        // Randomized operations against an integer clock model.
        doReset();
        base     = validCount;
        expValid = 0;
        mState   = 0;
        sh0 = 0; sh1 = 0; sh2 = 0;
        cm0 = 0; cm1 = 0; cm2 = 0;
        for (int n = 0; n < 60; n++) begin
            if (mState == 0) begin
                c0 = int'($urandom_range(0, 23));
                c1 = int'($urandom_range(0, 59));
                c2 = int'($urandom_range(0, 59));
                cur_time = packTime(c0, c1, c2);
            end
            op = int'($urandom_range(0, 2));
            if (op == 0) begin
                press(B_MODE);
                if (mState == 0) begin
                    sh0 = c0; sh1 = c1; sh2 = c2;
                    mState = 1;
                end else if (mState < 3) begin
                    mState = mState + 1;
                end else begin
                    cm0 = sh0; cm1 = sh1; cm2 = sh2;
                    mState = 0;
                    expValid = expValid + 1;
                end
            end else begin
                press(op == 1 ? B_UP : B_DOWN);
                case (mState)
                    1: sh0 = (sh0 + (op == 1 ? 1 : 23)) % 24;
                    2: sh1 = (sh1 + (op == 1 ? 1 : 59)) % 60;
                    3: sh2 = (sh2 + (op == 1 ? 1 : 59)) % 60;
                    default: ;
                endcase
            end
            checkOutput($sformatf("rnd%0d_time", n), 32'(set_time),
                        32'(mState != 0 ? packTime(sh0, sh1, sh2) : packTime(cm0, cm1, cm2)));
            checkOutput($sformatf("rnd%0d_edit", n), 32'(editing), 32'(mState != 0));
        end
        checkOutput("rndValidCount", 32'(validCount - base), 32'(expValid));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
